wide_add_sequencer: RTL and testbench

//  Multi-precision add/subtract engine: one shared 16-bit carry-lookahead adder (CLA_16bit) is

---
 rtl/wide_add_sequencer_pkg.sv | 18 +
 rtl/wide_add_sequencer_cla16.sv | 54 +++++
 rtl/wide_add_sequencer.sv | 138 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package wide_add_sequencer_pkg;

  // Slice width of the shared carry-lookahead adder.
  localparam int WORD_W = 16;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operation codes carried on in_op.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/wide_add_sequencer_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second-level
// lookahead across the group generate/propagate terms.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  cg;
  logic [15:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate, group carries by lookahead, then bit carries.
  always_comb begin
    gg = '0;
    pg = '0;
    cg = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end
    cg[0] = cin;
    cg[1] = gg[0] | (pg[0] & cin);
    cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & cin);
    cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g[4*k]   | (p[4*k]   & cg[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])   | (p[4*k+1] & p[4*k] & cg[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = cg[4];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract engine: one shared 16-bit CLA iterated over
// N_WORDS slices, LSB slice first, with the carry held in a register.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WORD_W  = wide_add_sequencer_pkg::WORD_W,
  parameter int N_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W*N_WORDS-1:0]   in_a,
  input  logic [WORD_W*N_WORDS-1:0]   in_b,
  input  logic                        in_op,
  input  logic                        in_cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*N_WORDS-1:0]   out_sum,
  output logic                        out_cout,
  output logic                        out_ovf,
  output logic                        out_zero
);

  localparam int IDX_W = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             carry_q, carry_d;
  logic [N_WORDS-1:0][WORD_W-1:0]   a_q, a_d;
  logic [N_WORDS-1:0][WORD_W-1:0]   b_q, b_d;
  logic [N_WORDS-1:0][WORD_W-1:0]   sum_q, sum_d;
  logic                             cout_q, cout_d;
  logic                             ovf_q, ovf_d;
  logic                             in_ready_q, in_ready_d;
  logic                             out_valid_q, out_valid_d;

  logic [WORD_W-1:0]                add_sum;
  logic                             add_cout;

  // The single shared slice adder; operands come from the slice muxes.
  cla_16bit u_cla (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state logic: operand capture, slice iteration and result handshake.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1, so only B and the carry-in change.
          a_d        = in_a;
          b_d        = (in_op == OP_SUB) ? ~in_b : in_b;
          carry_d    = (in_op == OP_SUB) ? 1'b1 : in_cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q] = add_sum;
        carry_d      = add_cout;
        if (idx_q == IDX_LAST) begin
          cout_d      = add_cout;
          ovf_d       = (a_q[IDX_LAST][WORD_W-1] == b_q[IDX_LAST][WORD_W-1])
                      & (add_sum[WORD_W-1] != a_q[IDX_LAST][WORD_W-1]);
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any operation in flight and clears results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = (sum_q == '0);

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with N_WORDS=4 (64-bit operands).
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_op = 1'b0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        op;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[8];

  wide_add_sequencer #(.N_WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present an operand set, wait for acceptance, then scramble the inputs.
  task automatic start_op(input vec_t v, input string tag);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = v.a;
    in_b = v.b;
    in_op = v.op;
    in_cin = v.cin;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_accept_timeout"}, 64'(guard >= 50), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    in_op = 1'($urandom);
    in_cin = 1'($urandom);
  endtask

  // Count edges from the accepting edge until out_valid rises.
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
  endtask

  task automatic check_out(input vec_t v, input string tag);
    chk({tag, "_sum"}, out_sum, v.sum);
    chk({tag, "_cout"}, 64'(out_cout), 64'(v.cout));
    chk({tag, "_ovf"}, 64'(out_ovf), 64'(v.ovf));
    chk({tag, "_zero"}, 64'(out_zero), 64'(v.zero));
    chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    start_op(v, tag);
    wait_result(tag);
    check_out(v, tag);
    handshake(tag);
  endtask

  initial begin
    vec_t v0;
    vec_t v1;
    // a, b, op, cin, sum, cout, ovf, zero
    vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1,
                64'h0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{64'h3, 64'h5, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{64'h5, 64'h5, 1'b1, 1'b0,
                64'h0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0000, 1'b0, 1'b1,
                64'h0001_0000_0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{64'h1234, 64'h5678, 1'b0, 1'b0,
                64'h68AC, 1'b0, 1'b0, 1'b0};

    // Asynchronous reset with the clock stopped.
    #2 rst = 1'b1;
    #3;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_sum", out_sum, 64'd0);
    chk("reset_out_cout", 64'(out_cout), 64'd0);
    chk("reset_out_ovf", 64'(out_ovf), 64'd0);
    #2 rst = 1'b0;
    #3 clk_en = 1'b1;

    // Table-driven operations.
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held while a new operand waits.
    v0 = vecs[6];
    v1 = vecs[4];
    start_op(v0, "bp_first");
    wait_result("bp_first");
    check_out(v0, "bp_first");
    @(negedge clk);
    in_valid = 1'b1;
    in_a = v1.a;
    in_b = v1.b;
    in_op = v1.op;
    in_cin = v1.cin;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("bp_hold%0d_in_ready", c), 64'(in_ready), 64'd0);
      chk($sformatf("bp_hold%0d_sum", c), out_sum, v0.sum);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_handshake_valid", 64'(out_valid), 64'd0);
    chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_second_accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_result("bp_second");
    check_out(v1, "bp_second");
    handshake("bp_second");

    // Reset in RUN with idx=2 and a live carry, then a clean operation.
    v0 = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
    start_op(v0, "abort");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_sum", out_sum, 64'd0);
    #1 rst = 1'b0;
    run_vec(vecs[7], "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
